// File: rtl/clip_transport_ctrl.sv
// Record/playback transport controller for the two-clip audio recorder.
// Conditions the raw buttons/switch, runs the IDLE/RECORD/PLAY machine and
// drives clip-buffer addressing plus the clip/mode status pair for the LEDs.

// Two-flop synchronizer followed by a stable-for-N-cycles debounce filter.
module clip_debounce #(
    parameter int CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic dout
);
    localparam int CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic s1, s2;
    logic [CW-1:0] cnt;

    // Metastability guard for the asynchronous raw input.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
        end
    end

    // Accept the synchronized level only after CYCLES consecutive mismatches.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else if (s2 == dout) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt  <= '0;
            dout <= s2;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

module clip_transport_ctrl #(
    parameter int CLIP_AW         = 15,
    parameter int SAMPLE_DIV      = 12500,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               btn_record,
    input  logic               btn_play,
    input  logic               sw_clip,
    output logic               clipNum,
    output logic               recordOrPlay,
    output logic               busy,
    output logic [CLIP_AW:0]   mem_addr,
    output logic               mem_we,
    output logic               mem_re,
    output logic               sample_tick
);
    localparam int NUM_IN = 3;
    localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_RECORD, S_PLAY} state_t;

    // index 0 = record button, 1 = play button, 2 = clip switch
    logic [NUM_IN-1:0] raw, db, db_q;
    logic rec_press, play_press, sw_db;

    assign raw = {sw_clip, btn_play, btn_record};

    genvar g;
    generate
        for (g = 0; g < NUM_IN; g++) begin : g_db
            clip_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
                .clock (clock),
                .reset (reset),
                .din   (raw[g]),
                .dout  (db[g])
            );
        end
    endgenerate

    // Previous debounced levels for rising-edge press detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) db_q <= '0;
        else       db_q <= db;
    end

    assign rec_press  = db[0] & ~db_q[0];
    assign play_press = db[1] & ~db_q[1];
    assign sw_db      = db[2];

    // Free-running sample divider; the tick is registered alongside the
    // memory strobes so both land on the same cycle.
    logic [DW-1:0] div, div_nxt;
    logic          tick_nxt;

    assign div_nxt  = (div == DIV_LAST) ? '0 : div + 1'b1;
    assign tick_nxt = (div_nxt == DIV_LAST);

    // Divider count and tick output.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div         <= '0;
            sample_tick <= 1'b0;
        end else begin
            div         <= div_nxt;
            sample_tick <= tick_nxt;
        end
    end

    state_t                  state, state_nxt;
    logic                    clip_q, clip_nxt;
    logic [CLIP_AW-1:0]      offset, off_nxt;
    logic [1:0][CLIP_AW:0]   len, len_nxt;
    logic                    clipnum_nxt, rop_nxt, busy_nxt, we_nxt, re_nxt;
    logic [CLIP_AW:0]        addr_nxt;
    logic [CLIP_AW:0]        off_plus1;

    assign off_plus1 = {1'b0, offset} + 1'b1;

    // State and registered outputs; reset discards recorded lengths.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            clip_q       <= 1'b0;
            offset       <= '0;
            len          <= '0;
            clipNum      <= 1'b0;
            recordOrPlay <= 1'b0;
            busy         <= 1'b0;
            mem_addr     <= '0;
            mem_we       <= 1'b0;
            mem_re       <= 1'b0;
        end else begin
            state        <= state_nxt;
            clip_q       <= clip_nxt;
            offset       <= off_nxt;
            len          <= len_nxt;
            clipNum      <= clipnum_nxt;
            recordOrPlay <= rop_nxt;
            busy         <= busy_nxt;
            mem_addr     <= addr_nxt;
            mem_we       <= we_nxt;
            mem_re       <= re_nxt;
        end
    end

    // Transport next-state and next-output decode. A tick coinciding with a
    // stop press still performs its access before returning to IDLE.
    always_comb begin
        state_nxt   = state;
        clip_nxt    = clip_q;
        off_nxt     = offset;
        len_nxt     = len;
        clipnum_nxt = clipNum;
        rop_nxt     = recordOrPlay;
        addr_nxt    = mem_addr;
        we_nxt      = 1'b0;
        re_nxt      = 1'b0;
        case (state)
            S_IDLE: begin
                clipnum_nxt = sw_db;
                if (rec_press) begin
                    clip_nxt       = sw_db;
                    off_nxt        = '0;
                    len_nxt[sw_db] = '0;
                    rop_nxt        = 1'b0;
                    state_nxt      = S_RECORD;
                end else if (play_press && (len[sw_db] != '0)) begin
                    clip_nxt  = sw_db;
                    off_nxt   = '0;
                    rop_nxt   = 1'b1;
                    state_nxt = S_PLAY;
                end
            end
            S_RECORD: begin
                clipnum_nxt = clip_q;
                if (tick_nxt) begin
                    we_nxt          = 1'b1;
                    addr_nxt        = {clip_q, offset};
                    len_nxt[clip_q] = off_plus1;
                    off_nxt         = offset + 1'b1;
                    if (rec_press || (offset == '1)) state_nxt = S_IDLE;
                end else if (rec_press) begin
                    state_nxt = S_IDLE;
                end
            end
            S_PLAY: begin
                clipnum_nxt = clip_q;
                if (tick_nxt) begin
                    re_nxt   = 1'b1;
                    addr_nxt = {clip_q, offset};
                    off_nxt  = offset + 1'b1;
                    if (play_press || (off_plus1 == len[clip_q])) state_nxt = S_IDLE;
                end else if (play_press) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        busy_nxt = (state_nxt != S_IDLE);
    end
endmodule
